// File: rtl/prpg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prpg_pkg                                                           |
// | Shared state encoding, default feedback taps and LFSR/MISR helper. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package prpg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] c_default_taps = 3'b110;

  // Callers zero-extend to 32 bits so one helper serves any WIDTH up to 32.
  function automatic logic lfsr_fb(input logic [31:0] q, input logic [31:0] mask);
    return ^(q & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prpg_misr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prpg_misr                                                          |
// | Multiple-input signature register compacting unit responses.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module prpg_misr
  import prpg_pkg::*;
#(
  parameter int              WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS = c_default_taps
) (
  input  logic             clk,
  input  logic             set,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[WIDTH-2:0], lfsr_fb(32'(r_sig), 32'(TAPS))} ^ resp;
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/prpg_bist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prpg_bist_ctrl                                                     |
// | BIST sequencer: seeds a PRPG, streams patterns, checks MISR sig.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module prpg_bist_ctrl
  import prpg_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = c_default_taps,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             set,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [WIDTH-1:0] exp_sig,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_exp;
  logic             r_done;
  logic             r_pass;
  logic [WIDTH-1:0] r_sig;

  logic [WIDTH-1:0] w_misr;
  logic             w_misr_clr;
  logic             w_misr_en;
  logic             w_run;

  assign w_run      = (r_state == ST_RUN);
  assign w_misr_clr = (r_state == ST_IDLE) && start;
  assign w_misr_en  = w_run && !abort;

  prpg_misr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_misr (
    .clk  (clk),
    .set  (set),
    .clr  (w_misr_clr),
    .en   (w_misr_en),
    .resp (resp),
    .sig  (w_misr)
  );

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      r_state <= ST_IDLE;
      r_lfsr  <= '1;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_sig   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR, so substitute all-ones.
            r_lfsr  <= (seed == '0) ? '1 : seed;
            r_cnt   <= num_pat;
            r_exp   <= exp_sig;
            r_pass  <= 1'b0;
            r_sig   <= '0;
            r_state <= ST_SEED;
          end
        end
        ST_SEED: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != '0) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_CHECK;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], lfsr_fb(32'(r_lfsr), 32'(TAPS))};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          r_sig   <= w_misr;
          r_pass  <= (w_misr == r_exp);
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pat_valid = w_run;
  assign pat_out   = w_run ? r_lfsr : '0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule
`default_nettype wire

// File: doc/prpg_bist_ctrl.md
Name: prpg_bist_ctrl

Overview:
Built-in self-test sequencer for the pseudo-random pattern generator datapath. On a start request it seeds an internal LFSR-based PRPG and streams a programmable number of patterns to a unit under test. It compacts the unit's responses in a MISR and compares the final signature against an expected value. It sits between a test master (start/abort/config) and the logic under test.

Parameters:
WIDTH, 3, pattern, seed, response and signature width in bits.
TAPS, 3'b110, feedback mask shared by LFSR and MISR; fb = XOR of q bits where TAPS bit set (default fb = q[2]^q[1], maximal length 7).
CNT_W, 8, width of the pattern-count field.

Ports:
clk  input  1  system clock, rising edge.
set  input  1  asynchronous, active-high reset.
start  input  1  begin session; sampled in IDLE only.
abort  input  1  cancel session; honoured in SEED/RUN.
seed  input  WIDTH  initial LFSR value; captured on start.
num_pat  input  CNT_W  patterns to apply; captured on start.
exp_sig  input  WIDTH  expected signature; captured on start.
resp  input  WIDTH  response from unit under test; sampled while pat_valid=1.
pat_out  output  WIDTH  current pattern.
pat_valid  output  1  pat_out is being applied this cycle.
busy  output  1  session in progress (state != IDLE).
done  output  1  one-cycle pulse at session completion.
pass  output  1  signature matched; held until next start.
signature  output  WIDTH  final MISR value; held until next start.

Behaviour:
- Reset (set=1, async): state=IDLE; lfsr=all-ones; misr=0; cnt=0. Outputs: pat_out=0, pat_valid=0, busy=0, done=0, pass=0, signature=0.
- LFSR step: next = {q[WIDTH-2:0], fb(q)}.
- MISR step: next = {m[WIDTH-2:0], fb(m)} ^ resp.
- States: IDLE, SEED, RUN, CHECK, DONE.
- IDLE: on start=1, capture config and go to SEED.
  - lfsr <= seed; seed==0 is replaced by all-ones to avoid lock-up.
  - misr <= 0; cnt <= num_pat; pass <= 0; signature <= 0.
- SEED: one cycle. Go to RUN if cnt!=0, else to CHECK.
- RUN:
  - pat_valid=1 and pat_out=lfsr (combinational from state and lfsr).
  - Each cycle: misr <= step(misr, resp); lfsr advances; cnt decrements.
  - When cnt==1, go to CHECK.
  - The unit under test is combinational; resp is sampled on the same edge the pattern is retired.
- CHECK: one cycle. signature <= misr; pass <= (misr==exp_sig). Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0 gives done high during cycle N+3, where N=num_pat (N=0 gives 3).
- pat_out=0 whenever pat_valid=0.
- start while busy is ignored. Config inputs are ignored after capture.
- abort in SEED or RUN: go to IDLE next edge; no done pulse; pass=0; signature=0. abort in CHECK or DONE is ignored.
- start and abort both high in IDLE: start wins.
- num_pat above 7 wraps the LFSR sequence; this is legal.
- set mid-session: immediate return to the reset values above. No partial result is retained.

Decomposition:
- Shared package prpg_pkg holds:
  - state encoding (IDLE=0, SEED=1, RUN=2, CHECK=3, DONE=4; 3-bit);
  - default TAPS constant;
  - lfsr_fb function (masked XOR reduce).
- One natural sub-module, prpg_misr: WIDTH/TAPS parameters; clk, set, clr, en, resp, sig.
- LFSR, counter and FSM stay in the top level.

Test Plan:
1. Loopback (resp=pat_out), seed=111, num_pat=7, exp_sig=011 -> pat_out 111,110,100,001,010,101,011 on consecutive cycles with pat_valid=1; done at cycle 10 after start; signature=011; pass=1.
2. Same stimulus, exp_sig=000 -> signature=011, pass=0, done still pulses once.
3. seed=000, num_pat=7, loopback -> identical to scenario 1 (all-ones substitution).
4. num_pat=0 -> pat_valid never high; done at cycle 3; signature=000; pass=(exp_sig==000).
5. Abort after 3 RUN cycles -> IDLE on next edge, busy=0, no done, pass=0. A new start then completes scenario 1 correctly.
6. set pulsed mid-RUN, and start pulsed while busy -> all outputs 0 immediately on set; the busy-time start causes no restart or extra done.
